// File: rtl/arm_alu_ex_stage_if.sv
// ============================================================================
// Module      : arm_alu_ex_stage_if
// Description : Operand/result bundle between the issue logic and the ALU
//               execute stage. ARM_ALU_SHIFTER_CARRY_EN adds shifter_carry.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface arm_alu_ex_stage_if;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_op;
  logic        s_bit;
  logic [31:0] Rn;
  logic [31:0] N;
`ifdef ARM_ALU_SHIFTER_CARRY_EN
  logic        shifter_carry;
`endif
  logic        out_valid;
  logic [31:0] result;
  logic        wb_en;
  logic [3:0]  flags;

  modport master (
`ifdef ARM_ALU_SHIFTER_CARRY_EN
    output shifter_carry,
`endif
    output in_valid, stall, flush, alu_op, s_bit, Rn, N,
    input  out_valid, result, wb_en, flags
  );

  modport slave (
`ifdef ARM_ALU_SHIFTER_CARRY_EN
    input  shifter_carry,
`endif
    input  in_valid, stall, flush, alu_op, s_bit, Rn, N,
    output out_valid, result, wb_en, flags
  );
endinterface

`default_nettype wire

// File: rtl/arm_alu_ex_stage.sv
// ============================================================================
// Module      : arm_alu_ex_stage
// Description : Single-cycle ARM data-processing ALU execute stage with
//               registered result, writeback enable and NZCV flags.
//               ARM_ALU_SHIFTER_CARRY_EN: logical ops take C from shifter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module arm_alu_ex_stage (
  input  wire logic          clk,
  input  wire logic          reset,
  arm_alu_ex_stage_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  logic        out_valid_q, out_valid_d;
  logic        wb_en_q,     wb_en_d;
  logic [31:0] result_q,    result_d;
  logic [3:0]  flags_q,     flags_d;

  logic [31:0] op_a, op_b, logic_res, alu_res;
  logic        carry_in, is_arith, is_test, logical_c, alu_c, alu_v;
  logic [32:0] sum;

`ifdef ARM_ALU_SHIFTER_CARRY_EN
  assign logical_c = bus.shifter_carry;
`else
  assign logical_c = flags_q[1];
`endif

  assign is_test = (bus.alu_op[3:2] == 2'b10);

  // Every arithmetic op is folded onto one adder: subtraction is a + ~b + cin,
  // so the adder carry-out is directly the ARM "not borrow" C flag.
  always_comb begin
    op_a      = bus.Rn;
    op_b      = bus.N;
    carry_in  = 1'b0;
    is_arith  = 1'b0;
    logic_res = 32'h0;
    case (bus.alu_op)
      OP_AND, OP_TST: logic_res = bus.Rn & bus.N;
      OP_EOR, OP_TEQ: logic_res = bus.Rn ^ bus.N;
      OP_SUB, OP_CMP: begin op_b = ~bus.N; carry_in = 1'b1; is_arith = 1'b1; end
      OP_RSB:         begin op_a = bus.N; op_b = ~bus.Rn; carry_in = 1'b1; is_arith = 1'b1; end
      OP_ADD, OP_CMN: is_arith = 1'b1;
      OP_ADC:         begin carry_in = flags_q[1]; is_arith = 1'b1; end
      OP_SBC:         begin op_b = ~bus.N; carry_in = flags_q[1]; is_arith = 1'b1; end
      OP_RSC:         begin op_a = bus.N; op_b = ~bus.Rn; carry_in = flags_q[1]; is_arith = 1'b1; end
      OP_ORR:         logic_res = bus.Rn | bus.N;
      OP_MOV:         logic_res = bus.N;
      OP_BIC:         logic_res = bus.Rn & ~bus.N;
      OP_MVN:         logic_res = ~bus.N;
      default:        logic_res = 32'h0;
    endcase
    sum     = {1'b0, op_a} + {1'b0, op_b} + {32'h0, carry_in};
    alu_res = is_arith ? sum[31:0] : logic_res;
    alu_c   = is_arith ? sum[32] : logical_c;
    alu_v   = is_arith ? ((op_a[31] == op_b[31]) && (sum[31] != op_a[31])) : flags_q[0];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    wb_en_d     = wb_en_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      wb_en_d     = 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        out_valid_d = 1'b1;
        wb_en_d     = !is_test;
        result_d    = alu_res;
        if (bus.s_bit || is_test) begin
          flags_d = {alu_res[31], (alu_res == 32'h0), alu_c, alu_v};
        end
      end else begin
        out_valid_d = 1'b0;
        wb_en_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      result_q    <= 32'h0;
      flags_q     <= 4'b0000;
    end else begin
      out_valid_q <= out_valid_d;
      wb_en_q     <= wb_en_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_arm_alu_ex_stage.sv
// ============================================================================
// Module      : tb_arm_alu_ex_stage
// Description : Directed vector table plus randomized run against a
//               behavioural ARM ALU model. Honors ARM_ALU_SHIFTER_CARRY_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arm_alu_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  arm_alu_ex_stage_if bus ();

  arm_alu_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        s;
    logic [31:0] rn;
    logic [31:0] n;
    logic        iv;
    logic        stall;
    logic        flush;
    logic        rst;
    logic        sc;
    logic        ev;
    logic [31:0] er;
    logic        ew;
    logic [3:0]  ef;
  } vec_t;

  vec_t tbl[$];

  // Reference model state.
  logic        m_valid = 1'b0;
  logic        m_wb = 1'b0;
  logic [31:0] m_result = 32'h0;
  logic [3:0]  m_flags = 4'h0;
  logic        sc_in = 1'b0;

  function automatic void add_row(input logic [3:0] op, input logic s, input logic [31:0] rn,
                                  input logic [31:0] n, input logic iv, input logic stall,
                                  input logic flush, input logic rst, input logic sc,
                                  input logic ev, input logic [31:0] er, input logic ew,
                                  input logic [3:0] ef);
    vec_t v;
    v.op = op; v.s = s; v.rn = rn; v.n = n; v.iv = iv; v.stall = stall; v.flush = flush;
    v.rst = rst; v.sc = sc; v.ev = ev; v.er = er; v.ew = ew; v.ef = ef;
    tbl.push_back(v);
  endfunction

  // Plain integer arithmetic: sub computes x - y - extra, add computes x + y + extra.
  function automatic void arith(input logic [31:0] x, input logic [31:0] y, input bit sub,
                                input int extra, output logic [31:0] r, output bit c, output bit v);
    longint ux, uy, sx, sy, t, st;
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sub) begin
      t  = ux - uy - extra;
      c  = (ux >= uy + extra);
      st = sx - sy - extra;
    end else begin
      t  = ux + uy + extra;
      c  = (t > 64'sh0FFFF_FFFF);
      st = sx + sy + extra;
    end
    r = t[31:0];
    v = (st > 64'sd2147483647) || (st < -64'sd2147483648);
  endfunction

  task automatic model_edge();
    logic [31:0] r;
    bit c, v, arith_op, cur_c, upd;
    cur_c = m_flags[1];
    c = cur_c;
    v = m_flags[0];
`ifdef ARM_ALU_SHIFTER_CARRY_EN
    c = sc_in;
`endif
    arith_op = 1'b1;
    case (bus.alu_op)
      4'd0, 4'd8:  begin r = bus.Rn & bus.N; arith_op = 0; end
      4'd1, 4'd9:  begin r = bus.Rn ^ bus.N; arith_op = 0; end
      4'd2, 4'd10: arith(bus.Rn, bus.N, 1, 0, r, c, v);
      4'd3:        arith(bus.N, bus.Rn, 1, 0, r, c, v);
      4'd4, 4'd11: arith(bus.Rn, bus.N, 0, 0, r, c, v);
      4'd5:        arith(bus.Rn, bus.N, 0, int'(cur_c), r, c, v);
      4'd6:        arith(bus.Rn, bus.N, 1, int'(!cur_c), r, c, v);
      4'd7:        arith(bus.N, bus.Rn, 1, int'(!cur_c), r, c, v);
      4'd12:       begin r = bus.Rn | bus.N; arith_op = 0; end
      4'd13:       begin r = bus.N; arith_op = 0; end
      4'd14:       begin r = bus.Rn & ~bus.N; arith_op = 0; end
      default:     begin r = ~bus.N; arith_op = 0; end
    endcase
    if (arith_op == 0) v = m_flags[0];
    upd = bus.s_bit || (bus.alu_op >= 4'd8 && bus.alu_op <= 4'd11);
    if (reset) begin
      m_valid = 0; m_wb = 0; m_result = 0; m_flags = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_wb = 0;
    end else if (bus.stall) begin
      // hold everything
    end else if (bus.in_valid) begin
      m_valid  = 1;
      m_wb     = !(bus.alu_op >= 4'd8 && bus.alu_op <= 4'd11);
      m_result = r;
      if (upd) m_flags = {r[31], (r == 32'h0), c, v};
    end else begin
      m_valid = 0; m_wb = 0;
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic s, input logic [31:0] rn,
                       input logic [31:0] n, input logic iv, input logic stall,
                       input logic flush, input logic rst, input logic sc);
    bus.alu_op = op; bus.s_bit = s; bus.Rn = rn; bus.N = n;
    bus.in_valid = iv; bus.stall = stall; bus.flush = flush; reset = rst;
    sc_in = sc;
`ifdef ARM_ALU_SHIFTER_CARRY_EN
    bus.shifter_carry = sc;
`endif
  endtask

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got valid=%b wb=%b flags=%b result=%h, expected valid=%b wb=%b flags=%b result=%h",
               name, act[37], act[36], act[35:32], act[31:0], exp[37], exp[36], exp[35:32], exp[31:0]);
    end
  endtask

  logic [3:0] f_mov, f_teq, f_mvn;

  initial begin
`ifdef ARM_ALU_SHIFTER_CARRY_EN
    f_mov = 4'b0110; f_teq = 4'b0101; f_mvn = 4'b1001;
`else
    f_mov = 4'b0100; f_teq = 4'b0111; f_mvn = 4'b1011;
`endif
    //      op    s  rn            n             iv st fl rs sc  ev er            ew ef
    add_row(4'h4, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0,  0, 32'h0,        0, 4'b0000);
    add_row(4'h4, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0,  0, 32'h0,        0, 4'b0000);
    add_row(4'h4, 1, 32'h7FFFFFFF, 32'h1,        1, 0, 0, 0, 0,  1, 32'h80000000, 1, 4'b1001);
    add_row(4'h2, 1, 32'd5,        32'd5,        1, 0, 0, 0, 0,  1, 32'h0,        1, 4'b0110);
    add_row(4'hA, 0, 32'd3,        32'd5,        1, 0, 0, 0, 0,  1, 32'hFFFFFFFE, 0, 4'b1000);
    add_row(4'h4, 1, 32'd9,        32'd9,        0, 0, 0, 0, 0,  0, 32'hFFFFFFFE, 0, 4'b1000);
    add_row(4'h4, 1, 32'hFFFFFFFF, 32'h1,        1, 0, 0, 0, 0,  1, 32'h0,        1, 4'b0110);
    add_row(4'h5, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0,  1, 32'h1,        1, 4'b0110);
    add_row(4'h4, 0, 32'd2,        32'd3,        1, 1, 0, 0, 0,  1, 32'h1,        1, 4'b0110);
    add_row(4'h4, 0, 32'd2,        32'd3,        1, 1, 0, 0, 0,  1, 32'h1,        1, 4'b0110);
    add_row(4'h4, 0, 32'd2,        32'd3,        1, 0, 0, 0, 0,  1, 32'd5,        1, 4'b0110);
    add_row(4'h4, 1, 32'd7,        32'd7,        1, 1, 1, 0, 0,  0, 32'd5,        0, 4'b0110);
    add_row(4'h4, 1, 32'd1,        32'd1,        1, 1, 1, 1, 0,  0, 32'h0,        0, 4'b0000);
    add_row(4'hD, 1, 32'h0,        32'h0,        1, 0, 0, 0, 1,  1, 32'h0,        1, f_mov);
    add_row(4'hA, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0,  1, 32'h0,        0, 4'b0110);
    add_row(4'h6, 1, 32'd10,       32'd3,        1, 0, 0, 0, 0,  1, 32'd7,        1, 4'b0010);
    add_row(4'h7, 1, 32'd1,        32'd10,       1, 0, 0, 0, 0,  1, 32'd9,        1, 4'b0010);
    add_row(4'h3, 1, 32'd1,        32'd0,        1, 0, 0, 0, 0,  1, 32'hFFFFFFFF, 1, 4'b1000);
    add_row(4'hB, 0, 32'h80000000, 32'h80000000, 1, 0, 0, 0, 0,  1, 32'h0,        0, 4'b0111);
    add_row(4'h9, 0, 32'd5,        32'd5,        1, 0, 0, 0, 0,  1, 32'h0,        0, f_teq);
    add_row(4'hE, 0, 32'hFF,       32'h0F,       1, 0, 0, 0, 0,  1, 32'hF0,       1, f_teq);
    add_row(4'hF, 1, 32'h0,        32'h0,        1, 0, 0, 0, 0,  1, 32'hFFFFFFFF, 1, f_mvn);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].s, tbl[i].rn, tbl[i].n, tbl[i].iv, tbl[i].stall,
            tbl[i].flush, tbl[i].rst, tbl[i].sc);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d", i),
            {bus.out_valid, bus.wb_en, bus.flags, bus.result},
            {tbl[i].ev, tbl[i].ew, tbl[i].ef, tbl[i].er});
    end

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h7FFFFFFF;
        1: b = 32'hFFFFFFFF;
        2: b = a;
        3: a = 32'h80000000;
        default: ;
      endcase
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a, b,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)));
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rand%0d", k),
            {bus.out_valid, bus.wb_en, bus.flags, bus.result},
            {m_valid, m_wb, m_flags, m_result});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arm_alu_ex_stage.md
ARM_ALU_EX_STAGE -- requirements
Module: arm_alu_ex_stage

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operation presented this cycle.
REQ-005 stall  input  1  hold all stage state.
REQ-006 flush  input  1  replace captured operation with a bubble.
REQ-007 alu_op  input  4  ARM data-processing opcode.
REQ-008 s_bit  input  1  update flags for opcodes 0000-0111 and 1100-1111.
REQ-009 Rn  input  32  first operand.
REQ-010 N  input  32  second operand from the shifter/sign-extender.
REQ-011 out_valid  output  1  registered result is valid.
REQ-012 result  output  32  registered ALU result.
REQ-013 wb_en  output  1  registered register-writeback enable.
REQ-014 flags  output  4  registered condition flags {N,Z,C,V}.

Function
REQ-015 Opcode map SHALL be:
- 0000 AND, 0001 EOR, 0010 SUB (Rn-N), 0011 RSB (N-Rn).
- 0100 ADD, 0101 ADC, 0110 SBC (Rn-N-!C), 0111 RSC (N-Rn-!C).
- 1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN.
- 1100 ORR, 1101 MOV (N), 1110 BIC (Rn&~N), 1111 MVN (~N).
REQ-016 Arithmetic SHALL be 33-bit internally; result is bits[31:0]; ADC/SBC/RSC use the current registered C flag.
REQ-017 On each rising edge, precedence SHALL be reset > flush > stall > capture.
REQ-018 Flush SHALL set out_valid=0 and wb_en=0; result and flags hold.
REQ-019 Stall without flush SHALL hold out_valid, result, wb_en and flags unchanged.
REQ-020 Capture with in_valid=1 SHALL load result, set out_valid=1, and set wb_en=0 for 10xx and 1 otherwise; latency is one cycle.
REQ-021 Capture with in_valid=0 SHALL set out_valid=0 and wb_en=0, hold result, and hold flags.
REQ-022 On a valid capture, flags SHALL update when s_bit=1 or alu_op=10xx (test ops always update); otherwise flags hold.
REQ-023 N flag = result[31] and Z flag = (result==0) for every flag update.
REQ-024 Add-type C = carry-out; subtract-type C = NOT borrow (1 when no borrow).
REQ-025 Add/subtract-type V = signed overflow of the effective operation.
REQ-026 Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) SHALL leave V unchanged; C follows REQ-032.
REQ-027 An operation that updates flags on edge k SHALL see the new C on edge k+1 (back-to-back ADC chaining with no bubble).

Reset
REQ-028 With reset=1 at a rising edge: out_valid=0, wb_en=0, result=32'h0, flags=4'b0000.
REQ-029 Reset SHALL override stall, flush and in_valid on the same edge.
REQ-030 An operation captured on the edge where reset is asserted SHALL be discarded.

Configuration
REQ-031 Macro ARM_ALU_SHIFTER_CARRY_EN, when defined, SHALL add input shifter_carry (1 bit), the shifter carry-out for the current operand.
REQ-032 C flag for logical ops SHALL be:
- Macro defined: C = shifter_carry.
- Macro undefined: C unchanged, and shifter_carry does not exist.

Verification
REQ-033 Reset and idle:
- Assert reset one cycle -> out_valid=0, wb_en=0, result=0, flags=0000.
- Idle with in_valid=0 -> all outputs hold.
REQ-034 ADD overflow: ADD, Rn=32'h7FFFFFFF, N=1, s_bit=1 -> next cycle result=32'h80000000, flags=1001, wb_en=1.
REQ-035 Subtract equal then compare:
- SUB, Rn=5, N=5, s_bit=1 -> result=0, flags=0110.
- Next cycle CMP, Rn=3, N=5 -> wb_en=0, flags=1000.
REQ-036 Carry chain, issued back-to-back with no bubble:
- ADD, Rn=32'hFFFFFFFF, N=1, s_bit=1 -> result=0, flags=0110.
- Then ADC, Rn=0, N=0, s_bit=0 -> result=1, flags stay 0110.
REQ-037 Stall and flush:
- ADD, Rn=2, N=3 with stall=1 for 2 cycles -> outputs hold prior values.
- Release stall -> result=5.
- Assert flush together with stall -> out_valid=0 on that edge.
REQ-038 Configuration variants:
- Macro defined: MOV, N=0, s_bit=1, shifter_carry=1 -> flags=0110.
- Macro undefined, same stimulus after reset -> flags=0100.
